// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into single short/long (and optional repeat) press events
// behind a one-entry valid/ready register. Define AUTO_REPEAT_EN to enable auto-repeat in LONG.
module button_event_ctrl #(
  parameter int          NUM_BTN      = 4,
  parameter int          ID_W         = 2,
  parameter logic [26:0] LONG_LIMIT   = 27'd99_999_999,
  parameter logic [26:0] REPEAT_LIMIT = 27'd24_999_999
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NUM_BTN-1:0] i_btn,
  input  logic               i_evt_ready,
  output logic               o_evt_valid,
  output logic [ID_W-1:0]    o_evt_id,
  output logic               o_evt_long,
  output logic               o_evt_rpt,
  output logic               o_busy,
  output logic               o_drop
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_LONG} state_t;

  localparam logic [26:0] CNT_MAX = (LONG_LIMIT > REPEAT_LIMIT) ? LONG_LIMIT : REPEAT_LIMIT;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_BTN-1:0] r_btn_prev;
  logic [NUM_BTN-1:0] w_rise;
  logic               w_any_rise;
  logic [ID_W-1:0]    w_first_id;
  logic [ID_W-1:0]    r_trk;
  logic               w_trk_lvl;
  logic [26:0]        r_count;
  logic [26:0]        w_count_nxt;
  logic               w_emit;
  logic               w_emit_long;
  logic               r_valid;
  logic [ID_W-1:0]    r_id;
  logic               r_long;
  logic               r_drop;
`ifdef AUTO_REPEAT_EN
  logic               w_emit_rpt;
  logic               r_rpt;
`endif

  // Saturating increment keeps the counter from wrapping even with odd limit settings
  function automatic logic [26:0] sat_inc(input logic [26:0] v);
    return (v == CNT_MAX) ? v : v + 27'd1;
  endfunction

  assign w_rise     = i_btn & ~r_btn_prev;
  assign w_any_rise = |w_rise;

  always_comb begin
    w_first_id = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (w_rise[i]) w_first_id = ID_W'(i);
    end
  end

  always_comb begin
    w_trk_lvl = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (r_trk == ID_W'(i)) w_trk_lvl = i_btn[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_any_rise) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (!w_trk_lvl)                 w_state_nxt = S_IDLE;
        else if (r_count == LONG_LIMIT) w_state_nxt = S_LONG;
      end
      S_LONG: if (!w_trk_lvl) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_emit      = 1'b0;
    w_emit_long = 1'b0;
`ifdef AUTO_REPEAT_EN
    w_emit_rpt  = 1'b0;
`endif
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: if (w_any_rise) w_count_nxt = '0;
      S_HOLD: begin
        if (!w_trk_lvl) begin
          w_emit = 1'b1;
        end else if (r_count == LONG_LIMIT) begin
          w_emit      = 1'b1;
          w_emit_long = 1'b1;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = sat_inc(r_count);
        end
      end
      S_LONG: begin
`ifdef AUTO_REPEAT_EN
        if (w_trk_lvl) begin
          if (r_count == REPEAT_LIMIT) begin
            w_emit      = 1'b1;
            w_emit_long = 1'b1;
            w_emit_rpt  = 1'b1;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = sat_inc(r_count);
          end
        end
`endif
      end
      default: w_count_nxt = r_count;
    endcase
  end

  // btn_prev resets to all ones so a button held through reset release is not a press
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_btn_prev <= '1;
      r_trk      <= '0;
      r_count    <= '0;
    end else begin
      r_btn_prev <= i_btn;
      r_count    <= w_count_nxt;
      if (r_state == S_IDLE && w_any_rise) r_trk <= w_first_id;
    end
  end

  // Event register: a new event only lands if the slot is empty or being consumed
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_long  <= 1'b0;
      r_drop  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_rpt   <= 1'b0;
`endif
    end else if (w_emit) begin
      if (!r_valid || i_evt_ready) begin
        r_valid <= 1'b1;
        r_id    <= r_trk;
        r_long  <= w_emit_long;
        r_drop  <= 1'b0;
`ifdef AUTO_REPEAT_EN
        r_rpt   <= w_emit_rpt;
`endif
      end else begin
        r_drop  <= 1'b1;
      end
    end else begin
      r_drop <= 1'b0;
      if (r_valid && i_evt_ready) r_valid <= 1'b0;
    end
  end

  assign o_evt_valid = r_valid;
  assign o_evt_id    = r_id;
  assign o_evt_long  = r_long;
  assign o_drop      = r_drop;
  assign o_busy      = (r_state != S_IDLE);
`ifdef AUTO_REPEAT_EN
  assign o_evt_rpt   = r_rpt;
`else
  assign o_evt_rpt   = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus random button/ready traffic,
// all checked every cycle against a hold-duration based reference model.
module tb_button_event_ctrl;
  localparam int NB = 4;
  localparam int IW = 2;
  localparam int L  = 10;
  localparam int R  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn;
  logic          rdy;
  logic          o_evt_valid;
  logic [IW-1:0] o_evt_id;
  logic          o_evt_long;
  logic          o_evt_rpt;
  logic          o_busy;
  logic          o_drop;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: a press is described by its tracked id and start edge
  int            m_cyc;
  bit            m_act;
  int            m_trk;
  int            m_t0;
  logic [NB-1:0] m_prev;
  logic          m_valid, m_long, m_rpt, m_drop;
  int            m_id;

  button_event_ctrl #(
    .NUM_BTN(NB), .ID_W(IW), .LONG_LIMIT(27'd10), .REPEAT_LIMIT(27'd4)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_btn(btn), .i_evt_ready(rdy),
    .o_evt_valid(o_evt_valid), .o_evt_id(o_evt_id), .o_evt_long(o_evt_long),
    .o_evt_rpt(o_evt_rpt), .o_busy(o_busy), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cyc   = 0;
    m_act   = 1'b0;
    m_trk   = 0;
    m_t0    = 0;
    m_prev  = '1;
    m_valid = 1'b0;
    m_id    = 0;
    m_long  = 1'b0;
    m_rpt   = 1'b0;
    m_drop  = 1'b0;
  endfunction

  function automatic void model_edge(input logic [NB-1:0] b, input logic r);
    logic emit = 1'b0;
    logic el   = 1'b0;
    logic er   = 1'b0;
    int   held;
    bit   found = 1'b0;
    if (m_act) begin
      held = m_cyc - m_t0;
      if (!b[m_trk]) begin
        m_act = 1'b0;
        if (held <= L + 1) emit = 1'b1;
      end else if (held == L + 1) begin
        emit = 1'b1;
        el   = 1'b1;
      end
`ifdef AUTO_REPEAT_EN
      else if (held > L + 1 && ((held - L - 1) % (R + 1)) == 0) begin
        emit = 1'b1;
        el   = 1'b1;
        er   = 1'b1;
      end
`endif
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (!found && b[i] && !m_prev[i]) begin
          found = 1'b1;
          m_act = 1'b1;
          m_trk = i;
          m_t0  = m_cyc;
        end
      end
    end
    m_prev = b;
    m_drop = 1'b0;
    if (emit) begin
      if (!m_valid || r) begin
        m_valid = 1'b1;
        m_id    = m_trk;
        m_long  = el;
        m_rpt   = er;
      end else begin
        m_drop = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    m_cyc++;
  endfunction

  task automatic compare_all();
    chk("evt_valid", 32'(o_evt_valid), 32'(m_valid));
    chk("evt_id",    32'(o_evt_id),    32'(m_id));
    chk("evt_long",  32'(o_evt_long),  32'(m_long));
    chk("evt_rpt",   32'(o_evt_rpt),   32'(m_rpt));
    chk("drop",      32'(o_drop),      32'(m_drop));
    chk("busy",      32'(o_busy),      32'(m_act));
  endtask

  task automatic step(input logic [NB-1:0] b, input logic r);
    btn = b;
    rdy = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [NB-1:0] b, input int n, input logic r);
    for (int k = 0; k < n; k++) step(b, r);
  endtask

  task automatic do_reset(input logic [NB-1:0] b);
    btn   = b;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    rst_n = 1'b1;
  endtask

  logic [NB-1:0] lvl;
  int            left [NB];

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    rdy   = 1'b1;
    model_reset();
    #2;
    do_reset('0);

    // Short press
    hold(4'b0001, 5, 1'b1);
    hold(4'b0000, 5, 1'b1);
    // Long press, repeats when enabled
    hold(4'b0100, 30, 1'b1);
    hold(4'b0000, 5, 1'b1);
    // Simultaneous rises: lowest wins, still-held btn3 ignored until re-pressed
    hold(4'b1010, 3, 1'b1);
    hold(4'b1000, 6, 1'b1);
    hold(4'b0000, 3, 1'b1);
    hold(4'b1000, 3, 1'b1);
    hold(4'b0000, 3, 1'b1);
    // Backpressure drop, then consume
    hold(4'b0001, 3, 1'b0);
    hold(4'b0000, 2, 1'b0);
    hold(4'b0010, 3, 1'b0);
    hold(4'b0000, 3, 1'b0);
    hold(4'b0000, 3, 1'b1);
    // Reset mid-HOLD with btn0 held across release
    hold(4'b0001, 4, 1'b1);
    do_reset(4'b0001);
    hold(4'b0001, 5, 1'b1);
    hold(4'b0000, 4, 1'b1);
    hold(4'b0001, 3, 1'b1);
    hold(4'b0000, 3, 1'b1);
    // Emit while the slot is full and being consumed in the same cycle
    hold(4'b0001, 3, 1'b0);
    hold(4'b0000, 3, 1'b0);
    hold(4'b0010, 3, 1'b0);
    hold(4'b0000, 1, 1'b1);
    hold(4'b0000, 3, 1'b1);

    // Random traffic with mixed press lengths, backpressure and occasional reset
    lvl = '0;
    for (int b = 0; b < NB; b++) left[b] = $urandom_range(1, 10);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (left[b] == 0) begin
          lvl[b]  = ~lvl[b];
          left[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 40) : $urandom_range(1, 8);
        end else begin
          left[b]--;
        end
      end
      step(lvl, ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 599) == 0) do_reset(lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
